fetch_unit: RTL and testbench

//  Parametrised instruction fetch stage: PC generator, 1-cycle synchronous iCache port, FQ_DEPTH-entry fetch queue.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Defines the fetch queue entry layout, the reset PC and the sequential PC step.
// Imported by the fetch unit, its queue and the front-end interface users.
package fetch_pkg;

  localparam int          FETCH_DATA_WIDTH = 32;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [FETCH_DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Front-end bundle: iCache request/response, redirect input and decode-side head handshake.
// Purely wires; no latency of its own.
// Decode backpressure is ready_i; the iCache side has no backpressure (fixed 1-cycle reply).
interface fetch_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  icache_req_o;
  logic [ADDR_WIDTH-1:0] icache_addr_o;
  logic [DATA_WIDTH-1:0] icache_rdata_i;
  logic                  redirect_i;
  logic [31:0]           redirect_pc_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [31:0]           pc_o;
  logic [DATA_WIDTH-1:0] inst_o;

  // The fetch unit drives the request and the queue head.
  modport master (
    output icache_req_o, icache_addr_o, valid_o, pc_o, inst_o,
    input  icache_rdata_i, redirect_i, redirect_pc_i, ready_i
  );

  // The surroundings (iCache, decode, branch unit) drive everything else.
  modport slave (
    input  icache_req_o, icache_addr_o, valid_o, pc_o, inst_o,
    output icache_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with single-cycle flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencer, 1-cycle iCache port, fetch queue. Optional macro: FETCH_PERF_EN.
// Latency: request in cycle 0, queue push cycle 1, head valid cycle 2 (3 cycles after a redirect).
// Backpressure: a request issues only while queue count plus the in-flight reply fits, so replies are never dropped.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 9,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int          FQ_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);
  localparam int             CW        = $clog2(FQ_DEPTH+1);
  localparam logic [CW:0]    OCC_LIMIT = FQ_DEPTH[CW:0];

  typedef struct packed {
    logic [31:0]           pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  logic [31:0]   pc_req;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] q_count;
  logic [CW:0]   occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  entry_t        push_data;
  entry_t        head;

  // Credit check: the reply already in flight owns a queue slot before any new request.
  always_comb begin
    occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight};
    issue     = reset_n && !bus.redirect_i && (occupancy < OCC_LIMIT);
    push      = inflight && !bus.redirect_i;
    pop       = (q_count != '0) && bus.ready_i && !bus.redirect_i;
    push_data = '{pc: inflight_pc, inst: bus.icache_rdata_i};
  end

  // PC sequencing and in-flight tracking; a redirect overrides everything else this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_req      <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (bus.redirect_i) begin
      pc_req   <= align_pc(bus.redirect_pc_i);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_req      <= pc_req + PC_STEP;
        inflight_pc <= pc_req;
      end
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

  assign bus.icache_req_o  = issue;
  assign bus.icache_addr_o = pc_req[ADDR_WIDTH+1:2];
  assign bus.valid_o       = (q_count != '0);
  assign bus.pc_o          = head.pc;
  assign bus.inst_o        = head.inst;

`ifdef FETCH_PERF_EN
  // Saturating event counters: delivered instructions, stalled head cycles, redirect cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
      perf_flush_o   <= '0;
    end else begin
      if (pop && (perf_fetched_o != 32'hFFFF_FFFF))
        perf_fetched_o <= perf_fetched_o + 32'd1;
      if (bus.valid_o && !bus.ready_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
      if (bus.redirect_i && (perf_flush_o != 32'hFFFF_FFFF))
        perf_flush_o <= perf_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 1-cycle iCache.
// Checks reset, streaming, backpressure, redirects, mid-run reset and (with FETCH_PERF_EN) counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   npop;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) fif ();

  fetch_unit #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .FQ_DEPTH   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fif)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched),
    .perf_stall_o   (perf_stall),
    .perf_flush_o   (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // iCache image: the word address is embedded in the instruction.
  function automatic logic [31:0] img(input logic [31:0] pc);
    return {16'hC0DE, 7'd0, pc[10:2]};
  endfunction

  // Behavioural iCache: returns the image word one cycle after the request.
  always @(posedge clk) begin
    if (fif.icache_req_o) fif.icache_rdata_i <= {16'hC0DE, 7'd0, fif.icache_addr_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Assert reset for two edges and release just after an edge: that cycle is cycle 0.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    fif.redirect_i    = 1'b0;
    fif.redirect_pc_i = 32'h0;
    fif.ready_i       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    chk("rst_valid", 32'(fif.valid_o), 32'd0);
    chk("rst_req",   32'(fif.icache_req_o), 32'd0);
    chk("rst_count", 32'(dut.q_count), 32'd0);
    chk("rst_pcreq", dut.pc_req, 32'h0);

    // 1: streaming with ready held high
    @(posedge clk); #1; reset_n = 1'b1;
    fif.ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (c == 0) begin
        chk("t1_req0",  32'(fif.icache_req_o), 32'd1);
        chk("t1_addr0", 32'(fif.icache_addr_o), 32'd0);
      end
      if (c < 2) begin
        chk("t1_valid_lat", 32'(fif.valid_o), 32'd0);
      end else begin
        chk("t1_valid", 32'(fif.valid_o), 32'd1);
        chk("t1_pc",    fif.pc_o, 32'(4 * (c - 2)));
        chk("t1_inst",  fif.inst_o, img(32'(4 * (c - 2))));
      end
      next_cycle();
    end

    // 2: ten cycles of backpressure, then drain
    fif.ready_i = 1'b0;
    do_reset();
    repeat (10) next_cycle();
    sample();
    chk("t2_count", 32'(dut.q_count), 32'd4);
    chk("t2_req",   32'(fif.icache_req_o), 32'd0);
    chk("t2_pcreq", dut.pc_req, 32'd16);
    chk("t2_head",  fif.pc_o, 32'd0);
    next_cycle();
    fif.ready_i = 1'b1;
    npop = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (fif.valid_o && npop < 8) begin
        chk("t2_pc",   fif.pc_o, 32'(4 * npop));
        chk("t2_inst", fif.inst_o, img(32'(4 * npop)));
        npop++;
      end
      next_cycle();
    end
    chk("t2_npop", 32'(npop), 32'd8);

    // 3: redirect with three queued entries and one in flight
    fif.ready_i = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    fif.redirect_i    = 1'b1;
    fif.redirect_pc_i = 32'h100;
    sample();
    chk("t3_count_pre", 32'(dut.q_count), 32'd3);
    chk("t3_infl_pre",  32'(dut.inflight), 32'd1);
    chk("t3_req_t",     32'(fif.icache_req_o), 32'd0);
    next_cycle();
    fif.redirect_i = 1'b0;
    sample();
    chk("t3_valid_t1", 32'(fif.valid_o), 32'd0);
    chk("t3_addr_t1",  32'(fif.icache_addr_o), 32'h40);
    next_cycle();
    sample();
    chk("t3_valid_t2", 32'(fif.valid_o), 32'd0);
    next_cycle();
    fif.ready_i = 1'b1;
    sample();
    chk("t3_valid_t3", 32'(fif.valid_o), 32'd1);
    chk("t3_pc_t3",    fif.pc_o, 32'h100);
    chk("t3_inst_t3",  fif.inst_o, img(32'h100));
    next_cycle();
    sample();
    chk("t3_pc_t4", fif.pc_o, 32'h104);

    // 4: unaligned redirect target, then back-to-back redirects
    next_cycle();
    fif.redirect_i    = 1'b1;
    fif.redirect_pc_i = 32'h203;
    next_cycle();
    fif.redirect_i = 1'b0;
    sample();
    chk("t4_addr",  32'(fif.icache_addr_o), 32'h80);
    next_cycle();
    next_cycle();
    sample();
    chk("t4_pc", fif.pc_o, 32'h200);
    next_cycle();
    fif.redirect_i    = 1'b1;
    fif.redirect_pc_i = 32'h40;
    next_cycle();
    fif.redirect_pc_i = 32'h80;
    next_cycle();
    fif.redirect_i = 1'b0;
    sample();
    chk("t4_b2b_addr",   32'(fif.icache_addr_o), 32'h20);
    chk("t4_b2b_valid2", 32'(fif.valid_o), 32'd0);
    next_cycle();
    sample();
    chk("t4_b2b_valid3", 32'(fif.valid_o), 32'd0);
    next_cycle();
    sample();
    chk("t4_b2b_valid4", 32'(fif.valid_o), 32'd1);
    chk("t4_b2b_pc",     fif.pc_o, 32'h80);

    // 5: asynchronous reset in the middle of a stream with toggling ready
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      fif.ready_i = c[0];
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_valid_async", 32'(fif.valid_o), 32'd0);
    chk("t5_req_async",   32'(fif.icache_req_o), 32'd0);
    chk("t5_count_async", 32'(dut.q_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fif.ready_i = 1'b1;
    sample();
    chk("t5_req0",    32'(fif.icache_req_o), 32'd1);
    chk("t5_addr0",   32'(fif.icache_addr_o), 32'd0);
    chk("t5_valid0",  32'(fif.valid_o), 32'd0);
    next_cycle();
    sample();
    chk("t5_valid1", 32'(fif.valid_o), 32'd0);
    next_cycle();
    sample();
    chk("t5_valid2", 32'(fif.valid_o), 32'd1);
    chk("t5_pc2",    fif.pc_o, 32'h0);

`ifdef FETCH_PERF_EN
    // 6: 3 stall cycles, 5 pops, 2 redirects (pop suppressed on the redirect cycle)
    fif.ready_i = 1'b0;
    do_reset();
    repeat (5) next_cycle();
    fif.ready_i = 1'b1;
    repeat (5) next_cycle();
    fif.redirect_i    = 1'b1;
    fif.redirect_pc_i = 32'h40;
    next_cycle();
    fif.redirect_pc_i = 32'h80;
    next_cycle();
    fif.redirect_i = 1'b0;
    fif.ready_i    = 1'b0;
    sample();
    chk("t6_fetched", perf_fetched, 32'd5);
    chk("t6_stall",   perf_stall, 32'd3);
    chk("t6_flush",   perf_flush, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
